// File: rtl/seven_seg_scan.sv
// seven_seg_scan -- time-multiplexed scan controller for a common-anode,
// multi-digit 7-segment display.
//
// A single hex decoder is shared by all NDIG digits. Each digit is shown for
// DIV cycles, preceded by BLANK_CYC cycles with every digit dark to suppress
// ghosting. A value written through load is held in a staging register and
// copied to the display (shadow) register only at the frame boundary, so a
// frame never shows a mix of old and new digits.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active low
//   load        1-cycle strobe: stage value/dp_in
//   value       hex nibbles, [3:0] = digit 0
//   dp_in       decimal points, bit i = digit i, 1 = lit
//   lz_en       suppress leading zeros (live level)
//   seg_n       segments {g..a}, active low
//   dp_n        decimal point, active low
//   an_n        digit enables, active low
//   load_ack    1-cycle pulse: staged value committed
//   pending     staged value is waiting for the frame boundary
//   frame_tick  1-cycle pulse in the last cycle of every frame
module seven_seg_scan #(
  parameter int NDIG      = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*NDIG-1:0]   value,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                lz_en,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [NDIG-1:0]     an_n,
  output logic                load_ack,
  output logic                pending,
  output logic                frame_tick
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW      = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reload values: the counter runs down to zero, so a state lasting N
  // cycles is loaded with N-1.
  localparam logic [CW-1:0] SHOW_LD  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     digit, digit_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;

  logic [4*NDIG-1:0] stage, shadow;
  logic [NDIG-1:0]   stage_dp, shadow_dp;

  logic [3:0]        cur_nib;
  logic              upper_zero;

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      digit <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      digit <= digit_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. With BLANK_CYC=0 SHOW chains directly into the next
  // digit's SHOW; only the reset state itself spends a cycle in BLANK.
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    cnt_nxt   = cnt - CW'(1);
    case (state)
      ST_BLANK: begin
        if (cnt == '0) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = SHOW_LD;
        end
      end
      ST_SHOW: begin
        if (cnt == '0) begin
          digit_nxt = (digit == LAST_DIG) ? '0 : digit + DW'(1);
          if (BLANK_CYC > 0) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = BLANK_LD;
          end else begin
            cnt_nxt   = SHOW_LD;
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign frame_tick = (state == ST_SHOW) && (cnt == '0) && (digit == LAST_DIG);

  // Load/commit handshake. A load in the boundary cycle leaves pending set
  // while the previous stage contents move to shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      stage_dp  <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      load_ack <= frame_tick && pending;
      if (frame_tick && pending) begin
        shadow    <= stage;
        shadow_dp <= stage_dp;
      end
      if (load) begin
        stage    <= value;
        stage_dp <= dp_in;
        pending  <= 1'b1;
      end else if (frame_tick) begin
        pending  <= 1'b0;
      end
    end
  end

  // Display outputs. A digit above 0 is a leading zero when it and every
  // more significant nibble are zero.
  always_comb begin
    an_n       = '1;
    seg_n      = 7'h7F;
    dp_n       = 1'b1;
    cur_nib    = shadow[4*digit +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if ((j >= int'(digit)) && (shadow[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    if (state == ST_SHOW) begin
      an_n[digit] = 1'b0;
      dp_n        = ~shadow_dp[digit];
      if (lz_en && (digit != '0) && upper_zero) seg_n = 7'h7F;
      else                                      seg_n = hex_to_seg(cur_nib);
    end
  end

endmodule
